// File: rtl/hart_debug_ctrl.sv
// rtl/hart_debug_ctrl.sv - hart-side debug responder: halt/resume handshake and abstract GPR access
module hart_debug_ctrl #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            haltreq,
    input  logic            resumereq,
    input  logic            ackhavereset,
    input  logic            cmd_valid,
    input  logic [31:0]     cmd,
    input  logic [2:0]      cmderr_clr,
    input  logic [XLEN-1:0] data0_in,
    output logic [XLEN-1:0] data0_out,
    output logic            data0_wen,
    output logic            halted,
    output logic            running,
    output logic            resumeack,
    output logic            havereset,
    output logic            busy,
    output logic [2:0]      cmderr,
    output logic            core_halt_req,
    input  logic            core_halted,
    output logic            core_resume_req,
    input  logic            core_resumed,
    output logic [4:0]      reg_addr,
    output logic [XLEN-1:0] reg_wdata,
    output logic            reg_we,
    output logic            reg_re,
    input  logic [XLEN-1:0] reg_rdata,
    input  logic            reg_rvalid
);

    typedef enum logic [2:0] {
        S_RUN, S_HALT_WAIT, S_HALTED, S_ACC_WR, S_ACC_RD, S_ACC_RD_WAIT, S_RESUME_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] data0_out_q, data0_out_d, reg_wdata_q, reg_wdata_d;
    logic [4:0]      reg_addr_q, reg_addr_d;
    logic [2:0]      cmderr_q, cmderr_d;
    logic            data0_wen_q, data0_wen_d, halted_q, halted_d, running_q, running_d;
    logic            resumeack_q, resumeack_d, havereset_q, havereset_d, busy_q, busy_d;
    logic            core_halt_req_q, core_halt_req_d, core_resume_req_q, core_resume_req_d;
    logic            reg_we_q, reg_we_d, reg_re_q, reg_re_d, resume_pend_q, resume_pend_d;

    logic [15:0] regno, regno_idx;
    logic        regno_ok, notsup, cmd_go;
    logic [2:0]  new_err;
    logic        unused_cmd_bits;

    assign regno           = cmd[15:0];
    assign regno_idx       = regno - 16'h1000;
    assign regno_ok        = (regno >= 16'h1000) && ({16'h0, regno_idx} < 32'(NREGS));
    assign notsup          = (cmd[31:24] != 8'd0) || (cmd[22:20] != 3'd2) || cmd[19] ||
                             (cmd[17] && !regno_ok);
    assign unused_cmd_bits = ^{cmd[23], cmd[18]};

    always_comb begin
        new_err = 3'd0;
        cmd_go  = 1'b0;
        if (cmd_valid && (cmderr_q == 3'd0)) begin
            if (busy_q)                  new_err = 3'd1;
            else if (notsup)             new_err = 3'd2;
            else if (state_q != S_HALTED) new_err = 3'd4;
            else if (cmd[17])            cmd_go  = 1'b1;
        end
    end

    always_comb begin
        state_d           = state_q;
        data0_out_d       = data0_out_q;
        reg_wdata_d       = reg_wdata_q;
        reg_addr_d        = reg_addr_q;
        halted_d          = halted_q;
        running_d         = running_q;
        resumeack_d       = resumeack_q;
        busy_d            = busy_q;
        core_halt_req_d   = core_halt_req_q;
        core_resume_req_d = core_resume_req_q;
        resume_pend_d     = resume_pend_q;
        data0_wen_d       = 1'b0;
        reg_we_d          = 1'b0;
        reg_re_d          = 1'b0;
        havereset_d       = havereset_q & ~ackhavereset;
        // Bitwise W1C clear first, so a fresh error in the same cycle overrides it.
        cmderr_d          = (new_err != 3'd0) ? new_err : (cmderr_q & ~cmderr_clr);

        if (busy_q && resumereq) resume_pend_d = 1'b1;

        case (state_q)
            S_RUN: begin
                if (haltreq) begin
                    state_d         = S_HALT_WAIT;
                    core_halt_req_d = 1'b1;
                    running_d       = 1'b0;
                end
            end
            S_HALT_WAIT: begin
                if (core_halted) begin
                    state_d         = S_HALTED;
                    core_halt_req_d = 1'b0;
                    halted_d        = 1'b1;
                end
            end
            S_HALTED: begin
                resume_pend_d = 1'b0;
                if (cmd_go) begin
                    state_d       = cmd[16] ? S_ACC_WR : S_ACC_RD;
                    busy_d        = 1'b1;
                    reg_addr_d    = regno[4:0];
                    reg_we_d      = cmd[16];
                    reg_re_d      = !cmd[16];
                    resume_pend_d = resumereq;
                    if (cmd[16]) reg_wdata_d = data0_in;
                end else if ((resumereq || resume_pend_q) && !haltreq) begin
                    state_d           = S_RESUME_WAIT;
                    resumeack_d       = 1'b0;
                    core_resume_req_d = 1'b1;
                end
            end
            S_ACC_WR: begin
                state_d = S_HALTED;
                busy_d  = 1'b0;
            end
            S_ACC_RD: state_d = S_ACC_RD_WAIT;
            S_ACC_RD_WAIT: begin
                if (reg_rvalid) begin
                    state_d     = S_HALTED;
                    busy_d      = 1'b0;
                    data0_out_d = reg_rdata;
                    data0_wen_d = 1'b1;
                end
            end
            S_RESUME_WAIT: begin
                if (core_resumed) begin
                    state_d           = S_RUN;
                    core_resume_req_d = 1'b0;
                    resumeack_d       = 1'b1;
                    halted_d          = 1'b0;
                    running_d         = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= S_RUN;
            data0_out_q       <= '0;
            reg_wdata_q       <= '0;
            reg_addr_q        <= '0;
            cmderr_q          <= '0;
            data0_wen_q       <= 1'b0;
            halted_q          <= 1'b0;
            running_q         <= 1'b1;
            resumeack_q       <= 1'b0;
            havereset_q       <= 1'b1;
            busy_q            <= 1'b0;
            core_halt_req_q   <= 1'b0;
            core_resume_req_q <= 1'b0;
            reg_we_q          <= 1'b0;
            reg_re_q          <= 1'b0;
            resume_pend_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            data0_out_q       <= data0_out_d;
            reg_wdata_q       <= reg_wdata_d;
            reg_addr_q        <= reg_addr_d;
            cmderr_q          <= cmderr_d;
            data0_wen_q       <= data0_wen_d;
            halted_q          <= halted_d;
            running_q         <= running_d;
            resumeack_q       <= resumeack_d;
            havereset_q       <= havereset_d;
            busy_q            <= busy_d;
            core_halt_req_q   <= core_halt_req_d;
            core_resume_req_q <= core_resume_req_d;
            reg_we_q          <= reg_we_d;
            reg_re_q          <= reg_re_d;
            resume_pend_q     <= resume_pend_d;
        end
    end

    assign data0_out       = data0_out_q;
    assign data0_wen       = data0_wen_q;
    assign halted          = halted_q;
    assign running         = running_q;
    assign resumeack       = resumeack_q;
    assign havereset       = havereset_q;
    assign busy            = busy_q;
    assign cmderr          = cmderr_q;
    assign core_halt_req   = core_halt_req_q;
    assign core_resume_req = core_resume_req_q;
    assign reg_addr        = reg_addr_q;
    assign reg_wdata       = reg_wdata_q;
    assign reg_we          = reg_we_q;
    assign reg_re          = reg_re_q;

endmodule

// File: tb/tb_hart_debug_ctrl.sv
// tb/tb_hart_debug_ctrl.sv - directed self-checking bench for hart_debug_ctrl
module tb_hart_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, haltreq, resumereq, ackhavereset, cmd_valid;
    logic [31:0] cmd, data0_in, data0_out, reg_wdata, reg_rdata;
    logic [2:0]  cmderr_clr, cmderr;
    logic        data0_wen, halted, running, resumeack, havereset, busy;
    logic        core_halt_req, core_halted, core_resume_req, core_resumed;
    logic [4:0]  reg_addr;
    logic        reg_we, reg_re, reg_rvalid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hart_debug_ctrl #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .haltreq(haltreq), .resumereq(resumereq),
        .ackhavereset(ackhavereset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmderr_clr(cmderr_clr), .data0_in(data0_in), .data0_out(data0_out),
        .data0_wen(data0_wen), .halted(halted), .running(running),
        .resumeack(resumeack), .havereset(havereset), .busy(busy), .cmderr(cmderr),
        .core_halt_req(core_halt_req), .core_halted(core_halted),
        .core_resume_req(core_resume_req), .core_resumed(core_resumed),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL reset_running got %b want 1", running); end
        n_cmp++; if (havereset !== 1'b1) begin n_bad++; $display("FAIL reset_havereset got %b want 1", havereset); end
        n_cmp++; if ({halted, resumeack, busy, cmderr, data0_wen, reg_we, reg_re, core_halt_req, core_resume_req} !== 11'd0)
            begin n_bad++; $display("FAIL reset_zero_outs got %b want 0", {halted, resumeack, busy, cmderr, data0_wen, reg_we, reg_re, core_halt_req, core_resume_req}); end
        n_cmp++; if (data0_out !== 32'h0) begin n_bad++; $display("FAIL reset_data0 got %h want 0", data0_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_cmd_while_running();
        cmd = 32'h0022_1005; cmd_valid = 1'b1;
        step(); cmd_valid = 1'b0;
        n_cmp++; if (cmderr !== 3'd4) begin n_bad++; $display("FAIL run_cmderr got %0d want 4", cmderr); end
        n_cmp++; if ({reg_re, reg_we, busy} !== 3'b000) begin n_bad++; $display("FAIL run_no_access got %b want 000", {reg_re, reg_we, busy}); end
        step();
        n_cmp++; if ({reg_re, reg_we} !== 2'b00) begin n_bad++; $display("FAIL run_no_access2 got %b want 00", {reg_re, reg_we}); end
        cmderr_clr = 3'd7; step(); cmderr_clr = 3'd0;
        n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL run_cmderr_clr got %0d want 0", cmderr); end
    endtask

    task automatic test_halt();
        int cnt = 0;
        haltreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (core_halt_req === 1'b1) cnt++;
        end
        n_cmp++; if (running !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_wait_status got r=%b h=%b want r=0 h=0", running, halted); end
        core_halted = 1'b1;
        step();
        n_cmp++; if (cnt !== 3 || core_halt_req !== 1'b0) begin n_bad++; $display("FAIL halt_req_len got %0d cycles (now %b) want 3 (now 0)", cnt, core_halt_req); end
        n_cmp++; if (halted !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL halt_status got h=%b r=%b want h=1 r=0", halted, running); end
        n_cmp++; if (havereset !== 1'b1) begin n_bad++; $display("FAIL havereset_hold got %b want 1", havereset); end
        ackhavereset = 1'b1; step(); ackhavereset = 1'b0;
        n_cmp++; if (havereset !== 1'b0) begin n_bad++; $display("FAIL havereset_ack got %b want 0", havereset); end
        haltreq = 1'b0;
    endtask

    task automatic test_write();
        data0_in = 32'hDEAD_BEEF; cmd = 32'h0023_100A; cmd_valid = 1'b1;
        step(); cmd_valid = 1'b0;
        n_cmp++; if ({reg_we, reg_re, busy} !== 3'b101) begin n_bad++; $display("FAIL wr_strobe got we/re/busy=%b want 101", {reg_we, reg_re, busy}); end
        n_cmp++; if (reg_addr !== 5'd10 || reg_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_addr_data got %0d/%h want 10/deadbeef", reg_addr, reg_wdata); end
        step();
        n_cmp++; if ({reg_we, busy, cmderr} !== 5'b0) begin n_bad++; $display("FAIL wr_done got we/busy/cmderr=%b want 0", {reg_we, busy, cmderr}); end
        data0_in = 32'h0000_0055; cmd = 32'h0023_1000; cmd_valid = 1'b1;
        step(); cmd_valid = 1'b0;
        n_cmp++; if (reg_we !== 1'b1 || reg_addr !== 5'd0 || reg_wdata !== 32'h55) begin n_bad++; $display("FAIL wr_x0 got we=%b addr=%0d data=%h want 1/0/55", reg_we, reg_addr, reg_wdata); end
        step();
    endtask

    task automatic test_read();
        int bcnt = 0;
        cmd = 32'h0022_100A; cmd_valid = 1'b1;
        step(); cmd_valid = 1'b0;
        if (busy === 1'b1) bcnt++;
        n_cmp++; if (reg_re !== 1'b1 || reg_addr !== 5'd10 || reg_we !== 1'b0) begin n_bad++; $display("FAIL rd_strobe got re=%b addr=%0d we=%b want 1/10/0", reg_re, reg_addr, reg_we); end
        step(); if (busy === 1'b1) bcnt++;
        n_cmp++; if (reg_re !== 1'b0) begin n_bad++; $display("FAIL rd_strobe_len got %b want 0", reg_re); end
        step(); if (busy === 1'b1) bcnt++;
        reg_rvalid = 1'b1; reg_rdata = 32'h1234_5678;
        step(); reg_rvalid = 1'b0;
        if (busy === 1'b1) bcnt++;
        n_cmp++; if (data0_out !== 32'h1234_5678 || data0_wen !== 1'b1) begin n_bad++; $display("FAIL rd_data got %h wen=%b want 12345678 wen=1", data0_out, data0_wen); end
        n_cmp++; if (bcnt !== 3) begin n_bad++; $display("FAIL rd_busy_len got %0d want 3", bcnt); end
        step();
        n_cmp++; if (data0_wen !== 1'b0) begin n_bad++; $display("FAIL rd_wen_pulse got %b want 0", data0_wen); end
    endtask

    task automatic test_notsup();
        cmd = 32'h0032_1005; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        n_cmp++; if (cmderr !== 3'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL notsup_size got %0d busy=%b want 2 busy=0", cmderr, busy); end
        cmderr_clr = 3'd1; step(); cmderr_clr = 3'd0;
        n_cmp++; if (cmderr !== 3'd2) begin n_bad++; $display("FAIL clr_partial got %0d want 2", cmderr); end
        cmderr_clr = 3'd2; step(); cmderr_clr = 3'd0;
        n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL clr_bit got %0d want 0", cmderr); end
        cmd = 32'h0022_1020; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        n_cmp++; if (cmderr !== 3'd2 || reg_re !== 1'b0) begin n_bad++; $display("FAIL notsup_regno got %0d re=%b want 2 re=0", cmderr, reg_re); end
        cmderr_clr = 3'd7; step(); cmderr_clr = 3'd0;
        cmd = 32'h0020_0000; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        n_cmp++; if ({cmderr, busy, reg_re, reg_we} !== 6'd0) begin n_bad++; $display("FAIL no_transfer got %b want 0", {cmderr, busy, reg_re, reg_we}); end
    endtask

    task automatic test_back_to_back();
        cmd = 32'h0022_1003; cmd_valid = 1'b1; step();
        cmd = 32'h0023_1004; step(); cmd_valid = 1'b0;
        n_cmp++; if (cmderr !== 3'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_err got %0d busy=%b want 1 busy=1", cmderr, busy); end
        n_cmp++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL b2b_no_write got %b want 0", reg_we); end
        reg_rvalid = 1'b1; reg_rdata = 32'hA5A5_0001; step(); reg_rvalid = 1'b0;
        n_cmp++; if (data0_out !== 32'hA5A5_0001 || data0_wen !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_first_done got %h wen=%b busy=%b want a5a50001/1/0", data0_out, data0_wen, busy); end
        cmd = 32'h0032_1005; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        n_cmp++; if (cmderr !== 3'd1) begin n_bad++; $display("FAIL err_sticky_ignore got %0d want 1", cmderr); end
        cmd = 32'h0023_1004; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        n_cmp++; if (reg_we !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL err_blocks_cmd got we=%b busy=%b want 0/0", reg_we, busy); end
        cmderr_clr = 3'd7; step(); cmderr_clr = 3'd0;
    endtask

    task automatic test_resume();
        haltreq = 1'b1; resumereq = 1'b1; step(); resumereq = 1'b0;
        step();
        n_cmp++; if (halted !== 1'b1 || core_resume_req !== 1'b0) begin n_bad++; $display("FAIL resume_blocked got h=%b crr=%b want 1/0", halted, core_resume_req); end
        haltreq = 1'b0; resumereq = 1'b1; step(); resumereq = 1'b0;
        n_cmp++; if (core_resume_req !== 1'b1 || resumeack !== 1'b0 || halted !== 1'b1) begin n_bad++; $display("FAIL resume_wait got crr=%b ack=%b h=%b want 1/0/1", core_resume_req, resumeack, halted); end
        step();
        core_resumed = 1'b1; core_halted = 1'b0; step(); core_resumed = 1'b0;
        n_cmp++; if ({resumeack, running, halted, core_resume_req} !== 4'b1100) begin n_bad++; $display("FAIL resume_done got ack/run/h/crr=%b want 1100", {resumeack, running, halted, core_resume_req}); end
    endtask

    task automatic test_resume_pending_and_reset();
        haltreq = 1'b1; step();
        core_halted = 1'b1; step(); haltreq = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL rehalt got %b want 1", halted); end
        cmd = 32'h0022_1001; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        resumereq = 1'b1; step(); resumereq = 1'b0;
        n_cmp++; if (core_resume_req !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL pend_held got crr=%b busy=%b want 0/1", core_resume_req, busy); end
        reg_rvalid = 1'b1; reg_rdata = 32'h0BAD_F00D; step(); reg_rvalid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || core_resume_req !== 1'b0 || data0_out !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL pend_rd_done got busy=%b crr=%b d=%h want 0/0/0badf00d", busy, core_resume_req, data0_out); end
        step();
        n_cmp++; if (core_resume_req !== 1'b1 || resumeack !== 1'b0) begin n_bad++; $display("FAIL pend_resume got crr=%b ack=%b want 1/0", core_resume_req, resumeack); end
        ackhavereset = 1'b1; rst_n = 1'b0; step(); rst_n = 1'b1; ackhavereset = 1'b0;
        n_cmp++; if ({running, halted, core_resume_req, resumeack, havereset} !== 5'b10001) begin n_bad++; $display("FAIL reset_in_resume got run/h/crr/ack/hr=%b want 10001", {running, halted, core_resume_req, resumeack, havereset}); end
    endtask

    initial begin
        rst_n = 1'b0; haltreq = 1'b0; resumereq = 1'b0; ackhavereset = 1'b0;
        cmd_valid = 1'b0; cmd = 32'h0; cmderr_clr = 3'd0; data0_in = 32'h0;
        core_halted = 1'b0; core_resumed = 1'b0; reg_rdata = 32'h0; reg_rvalid = 1'b0;
        test_reset();
        test_cmd_while_running();
        test_halt();
        test_write();
        test_read();
        test_notsup();
        test_back_to_back();
        test_resume();
        test_resume_pending_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
